// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: accepts one operand vector per handshake and staggers
// lane i by i extra cycles so the vector arrives at the PE array diagonal.
module operand_skew_feeder #(
    parameter int LANES       = 4,
    parameter int OPND_BWIDTH = 8,
    parameter int LEN_BWIDTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         STALL,
    input  logic                         START,
    input  logic [LEN_BWIDTH-1:0]        K_LEN,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [LANES*OPND_BWIDTH-1:0] IN_DATA,
    output logic [LANES*OPND_BWIDTH-1:0] OUT_OPND,
    output logic [LANES-1:0]             OUT_VALID,
    output logic                         BUSY,
    output logic                         DONE
);

    // Drain counter must hold LANES-1; keep at least one bit for LANES=1.
    localparam int DCW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [LEN_BWIDTH-1:0] remain;
    logic [DCW-1:0]        drain_cnt;
    logic                  busy_q;
    logic                  done_q;
    logic                  hs;

    assign IN_READY = (state == S_FEED) && !STALL;
    assign hs       = IN_VALID && IN_READY;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    // Job sequencing: count accepted vectors, then let the deepest lane drain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            remain    <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!STALL) begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        busy_q <= 1'b1;
                        if (K_LEN != '0) begin
                            state  <= S_FEED;
                            remain <= K_LEN;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FEED: begin
                    if (hs) begin
                        remain <= remain - LEN_BWIDTH'(1);
                        if (remain == LEN_BWIDTH'(1)) begin
                            if (LANES > 1) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DCW'(LANES - 1);
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DCW'(1)) begin
                        state     <= S_DONE;
                        drain_cnt <= '0;
                        done_q    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [OPND_BWIDTH-1:0] opnd_p [0:g];
        logic        [g:0]             vld_p;

        // Lane g delay line: g+1 stages, bubble enters stage 0 when no handshake.
        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int j = 0; j <= g; j++) begin
                    opnd_p[j] <= '0;
                end
                vld_p <= '0;
            end else if (!STALL) begin
                opnd_p[0] <= hs ? $signed(IN_DATA[g*OPND_BWIDTH +: OPND_BWIDTH]) : '0;
                vld_p[0]  <= hs;
                for (int j = 1; j <= g; j++) begin
                    opnd_p[j] <= opnd_p[j-1];
                    vld_p[j]  <= vld_p[j-1];
                end
            end
        end

        assign OUT_OPND[g*OPND_BWIDTH +: OPND_BWIDTH] = opnd_p[g];
        assign OUT_VALID[g]                           = vld_p[g];
    end

endmodule
